// File: rtl/crg_jtag_tap_ctrl_if.sv
// crg_jtag_tap_ctrl_if: pad-level JTAG pins plus the control/serial lines
// to the chip boundary-scan chain.
//
// Protocol: there is no valid/ready pair. tms/tdi are sampled by the TAP
// on tck rise, tdo/tdo_en change on tck fall, and the bsr_* controls are
// qualified by tck rise in the boundary-scan cells.
interface crg_jtag_tap_ctrl_if;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;
    logic bsr_tdo;
    logic bsr_tdi;
    logic bsr_capture;
    logic bsr_shift;
    logic bsr_update;
    logic bsr_mode;
    logic tlr_state;

    // Host / boundary-scan side: drives pins into the TAP
    modport master (
        output tms, tdi, bsr_tdo,
        input  tdo, tdo_en, bsr_tdi, bsr_capture, bsr_shift, bsr_update,
               bsr_mode, tlr_state
    );

    // TAP controller side
    modport slave (
        input  tms, tdi, bsr_tdo,
        output tdo, tdo_en, bsr_tdi, bsr_capture, bsr_shift, bsr_update,
               bsr_mode, tlr_state
    );
endinterface

// File: rtl/crg_jtag_tap_ctrl.sv
// crg_jtag_tap_ctrl: IEEE 1149.1 TAP controller (16-state FSM, IR, BYPASS,
// IDCODE) driving the chip boundary-scan chain.
// Optional feature macro CRG_JTAG_CLAMP_EN: when defined, opcode 0x3 is
// CLAMP (bsr_mode=1, DR path = bypass). When undefined 0x3 is BYPASS.
// state_dbg and ir_dbg expose the FSM state and the IR update latch.
module crg_jtag_tap_ctrl #(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0C3F
) (
    input  logic                tck,
    input  logic                trstn,
    crg_jtag_tap_ctrl_if.slave  jtag,
    output logic [3:0]          state_dbg,
    output logic [IR_WIDTH-1:0] ir_dbg
);

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SHIFT_DR = 4'd4,
        EXIT1_DR = 4'd5,
        PAUSE_DR = 4'd6,
        EXIT2_DR = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SHIFT_IR = 4'd11,
        EXIT1_IR = 4'd12,
        PAUSE_IR = 4'd13,
        EXIT2_IR = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(2);
`ifdef CRG_JTAG_CLAMP_EN
    localparam logic [IR_WIDTH-1:0] OP_CLAMP  = IR_WIDTH'(3);
`endif

    tap_state_t          state, next_state;
    logic [IR_WIDTH-1:0] ir_sr, ir_latch;
    logic                bypass_reg;
    logic [31:0]         idcode_sr;
    logic                sel_bsr, sel_idcode, mode_sel, dr_out;
    logic                tdo_q, tdo_en_q;

    // TAP state register; trstn forces Test-Logic-Reset at any time
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) state <= TLR;
        else        state <= next_state;
    end

    // Next-state graph, instruction decode and boundary-scan controls
    always_comb begin
        next_state = state;
        case (state)
            TLR:      next_state = jtag.tms ? TLR      : RTI;
            RTI:      next_state = jtag.tms ? SEL_DR   : RTI;
            SEL_DR:   next_state = jtag.tms ? SEL_IR   : CAP_DR;
            CAP_DR:   next_state = jtag.tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: next_state = jtag.tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: next_state = jtag.tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: next_state = jtag.tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: next_state = jtag.tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   next_state = jtag.tms ? SEL_DR   : RTI;
            SEL_IR:   next_state = jtag.tms ? TLR      : CAP_IR;
            CAP_IR:   next_state = jtag.tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: next_state = jtag.tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: next_state = jtag.tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: next_state = jtag.tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: next_state = jtag.tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   next_state = jtag.tms ? SEL_DR   : RTI;
            default:  next_state = TLR;
        endcase

        // Anything not EXTEST/SAMPLE/IDCODE falls through to the bypass path
        sel_bsr    = (ir_latch == OP_EXTEST) || (ir_latch == OP_SAMPLE);
        sel_idcode = (ir_latch == OP_IDCODE);
`ifdef CRG_JTAG_CLAMP_EN
        mode_sel   = (ir_latch == OP_EXTEST) || (ir_latch == OP_CLAMP);
`else
        mode_sel   = (ir_latch == OP_EXTEST);
`endif

        if (sel_bsr)         dr_out = jtag.bsr_tdo;
        else if (sel_idcode) dr_out = idcode_sr[0];
        else                 dr_out = bypass_reg;
    end

    // IR shift/update and DR shift paths, all on tck rise
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            ir_sr      <= OP_IDCODE;
            ir_latch   <= OP_IDCODE;
            bypass_reg <= 1'b0;
            idcode_sr  <= IDCODE_VAL;
        end else begin
            if (state == CAP_IR)
                ir_sr <= IR_WIDTH'(1);
            else if (state == SHIFT_IR)
                ir_sr <= {jtag.tdi, ir_sr[IR_WIDTH-1:1]};

            // The latch (and thus decode/bsr_mode) moves only here
            if (next_state == TLR)
                ir_latch <= OP_IDCODE;
            else if (state == UPD_IR)
                ir_latch <= ir_sr;

            if (!sel_bsr && !sel_idcode) begin
                if (state == CAP_DR)        bypass_reg <= 1'b0;
                else if (state == SHIFT_DR) bypass_reg <= jtag.tdi;
            end

            if (sel_idcode) begin
                if (state == CAP_DR)        idcode_sr <= IDCODE_VAL;
                else if (state == SHIFT_DR) idcode_sr <= {jtag.tdi, idcode_sr[31:1]};
            end
        end
    end

    // tdo/tdo_en retimed to tck fall so the host samples them on the next rise
    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else if (state == SHIFT_IR) begin
            tdo_q    <= ir_sr[0];
            tdo_en_q <= 1'b1;
        end else if (state == SHIFT_DR) begin
            tdo_q    <= dr_out;
            tdo_en_q <= 1'b1;
        end else begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end
    end

    assign jtag.tdo         = tdo_q;
    assign jtag.tdo_en      = tdo_en_q;
    assign jtag.bsr_tdi     = jtag.tdi;
    assign jtag.bsr_capture = (state == CAP_DR)   && sel_bsr;
    assign jtag.bsr_shift   = (state == SHIFT_DR) && sel_bsr;
    assign jtag.bsr_update  = (state == UPD_DR)   && sel_bsr;
    assign jtag.bsr_mode    = mode_sel;
    assign jtag.tlr_state   = (state == TLR);
    assign state_dbg        = state;
    assign ir_dbg           = ir_latch;

endmodule

// File: tb/tb_crg_jtag_tap_ctrl.sv
// Testbench for crg_jtag_tap_ctrl: directed TAP scans with hand-computed
// expected tdo streams, boundary-scan control counts and reset behaviour.
module tb_crg_jtag_tap_ctrl;

    // ---------------- clock / reset ----------------
    logic       tck = 1'b0;
    logic       trstn;
    logic [3:0] state_dbg;
    logic [3:0] ir_dbg;

    always #5 tck = ~tck;

    crg_jtag_tap_ctrl_if jif ();

    crg_jtag_tap_ctrl #(
        .IR_WIDTH   (4),
        .IDCODE_VAL (32'h1000_0C3F)
    ) dut (
        .tck       (tck),
        .trstn     (trstn),
        .jtag      (jif.slave),
        .state_dbg (state_dbg),
        .ir_dbg    (ir_dbg)
    );

    // Six-cell boundary-scan chain model fed by bsr_tdi, read via bsr_tdo
    localparam logic [5:0] BSR_CAP = 6'b101101;
    logic [5:0] bsr_model = 6'b0;
    int cap_cnt = 0, shf_cnt = 0, upd_cnt = 0;

    always @(posedge tck) begin
        if (jif.bsr_capture)    bsr_model <= BSR_CAP;
        else if (jif.bsr_shift) bsr_model <= {jif.bsr_tdi, bsr_model[5:1]};
        if (jif.bsr_capture) cap_cnt++;
        if (jif.bsr_shift)   shf_cnt++;
        if (jif.bsr_update)  upd_cnt++;
    end
    assign jif.bsr_tdo = bsr_model[0];

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Entered just after a tck fall; returns just after the next fall
    task automatic step(input logic m, input logic d);
        jif.tms = m;
        jif.tdi = d;
        @(posedge tck); #1;
        @(negedge tck); #1;
    endtask

    // n-bit scan from a SHIFT state; tdo read before each rise, last bit exits
    task automatic scan(input string tag, input int n, input logic [31:0] din,
                        input logic [31:0] exp);
        for (int i = 0; i < n; i++) exp_q.push_back(exp[i]);
        for (int i = 0; i < n; i++) begin
            logic [0:0] e;
            e = exp_q.pop_front();
            check_eq($sformatf("%s_tdo%0d", tag, i), 32'(jif.tdo), 32'(e));
            check_eq($sformatf("%s_en%0d", tag, i), 32'(jif.tdo_en), 32'd1);
            step(i == n - 1, din[i]);
        end
    endtask

    task automatic goto_shift_dr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // From RTI: load IR, checking the 0b0001 capture pattern, back to RTI
    task automatic load_ir(input logic [3:0] op);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        scan("ir_cap", 4, 32'(op), 32'h1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("ir_latch", 32'(ir_dbg), 32'(op));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c0, s0, u0;
        jif.tms = 1'b1;
        jif.tdi = 1'b0;
        trstn   = 1'b0;
        repeat (2) @(negedge tck);
        #1;
        check_eq("rst_state", 32'(state_dbg), 32'd0);
        check_eq("rst_tlr", 32'(jif.tlr_state), 32'd1);
        check_eq("rst_tdo_en", 32'(jif.tdo_en), 32'd0);
        check_eq("rst_tdo", 32'(jif.tdo), 32'd0);
        check_eq("rst_ir", 32'(ir_dbg), 32'h2);
        check_eq("rst_bsr", 32'({jif.bsr_capture, jif.bsr_shift, jif.bsr_update, jif.bsr_mode}), 32'd0);
        trstn = 1'b1;

        // IDCODE readout after reset
        step(1'b0, 1'b0);
        check_eq("rti_state", 32'(state_dbg), 32'd1);
        check_eq("rti_tlr", 32'(jif.tlr_state), 32'd0);
        goto_shift_dr();
        check_eq("shdr_state", 32'(state_dbg), 32'd4);
        scan("idcode", 32, 32'h0, 32'h1000_0C3F);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("idle_tdo_en", 32'(jif.tdo_en), 32'd0);
        check_eq("idle_tdo", 32'(jif.tdo), 32'd0);

        // PAUSE holds IDCODE shift contents, no recapture via EXIT2
        goto_shift_dr();
        scan("id_lo", 8, 32'h0, 32'h3F);
        step(1'b0, 1'b0);
        check_eq("pause_state", 32'(state_dbg), 32'd6);
        check_eq("pause_tdo_en", 32'(jif.tdo_en), 32'd0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        scan("id_hi", 8, 32'h0, 32'h0C);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // BYPASS: 1,0,1,1 in -> 0,1,0,1 out
        load_ir(4'hF);
        goto_shift_dr();
        scan("byp", 4, 32'b1101, 32'b1010);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Undefined opcode 0x7 -> 1-bit delay path
        load_ir(4'h7);
        goto_shift_dr();
        scan("op7", 8, 32'b1011_0010, 32'b0110_0100);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Opcode 0x3: CLAMP when enabled, BYPASS otherwise; never touches BSR
        load_ir(4'h3);
`ifdef CRG_JTAG_CLAMP_EN
        check_eq("op3_mode", 32'(jif.bsr_mode), 32'd1);
`else
        check_eq("op3_mode", 32'(jif.bsr_mode), 32'd0);
`endif
        c0 = cap_cnt; s0 = shf_cnt; u0 = upd_cnt;
        goto_shift_dr();
        scan("op3", 8, 32'b1110_0101, 32'b1100_1010);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("op3_bsr_cnt", 32'((cap_cnt - c0) + (shf_cnt - s0) + (upd_cnt - u0)), 32'd0);

        // EXTEST: bsr_mode, BSR control counts, tdo from bsr_tdo
        load_ir(4'h0);
        check_eq("ext_mode", 32'(jif.bsr_mode), 32'd1);
        c0 = cap_cnt; s0 = shf_cnt; u0 = upd_cnt;
        goto_shift_dr();
        check_eq("ext_shift_on", 32'(jif.bsr_shift), 32'd1);
        scan("ext", 6, 32'b010011, 32'(BSR_CAP));
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("ext_cap_cnt", 32'(cap_cnt - c0), 32'd1);
        check_eq("ext_shf_cnt", 32'(shf_cnt - s0), 32'd6);
        check_eq("ext_upd_cnt", 32'(upd_cnt - u0), 32'd1);
        check_eq("ext_chain", 32'(bsr_model), 32'b010011);
        check_eq("ext_mode_hold", 32'(jif.bsr_mode), 32'd1);

        // Async reset in the middle of an EXTEST DR shift
        goto_shift_dr();
        step(1'b0, 1'b1);
        check_eq("mid_shift", 32'(jif.bsr_shift), 32'd1);
        #2 trstn = 1'b0;
        #1;
        check_eq("arst_state", 32'(state_dbg), 32'd0);
        check_eq("arst_tlr", 32'(jif.tlr_state), 32'd1);
        check_eq("arst_tdo_en", 32'(jif.tdo_en), 32'd0);
        check_eq("arst_ir", 32'(ir_dbg), 32'h2);
        check_eq("arst_bsr", 32'({jif.bsr_capture, jif.bsr_shift, jif.bsr_update, jif.bsr_mode}), 32'd0);
        @(negedge tck); #1;
        trstn = 1'b1;

        // Five tms=1 from PAUSE_DR with EXTEST loaded -> TLR, IR=IDCODE
        step(1'b0, 1'b0);
        load_ir(4'h0);
        goto_shift_dr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("p5_pause", 32'(state_dbg), 32'd6);
        repeat (5) step(1'b1, 1'b0);
        check_eq("p5_state", 32'(state_dbg), 32'd0);
        check_eq("p5_tlr", 32'(jif.tlr_state), 32'd1);
        check_eq("p5_ir", 32'(ir_dbg), 32'h2);
        check_eq("p5_mode", 32'(jif.bsr_mode), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
